// File: rtl/issue_scheduler.sv
// Round-robin issue scheduler: offers one independent buffer slot per cycle to execution and
// tracks every slot through idle/queued/in-flight/done so no slot is issued twice.
module issue_scheduler #(
    parameter int unsigned bs           = 16,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [0:bs-1]            independent_instr,
    input  logic                     alloc_valid,
    input  logic [$clog2(bs)-1:0]    alloc_index,
    output logic                     issue_valid,
    output logic [$clog2(bs)-1:0]    issue_index,
    input  logic                     issue_ready,
    input  logic                     done_valid,
    input  logic [$clog2(bs)-1:0]    done_index,
    output logic                     free_valid,
    output logic [$clog2(bs)-1:0]    free_index,
    output logic [$clog2(bs+1)-1:0]  inflight,
    output logic                     err
);

    localparam int unsigned IW = $clog2(bs);
    localparam int unsigned CW = $clog2(bs + 1);

    localparam logic [1:0] SIdle     = 2'd0;
    localparam logic [1:0] SQueued   = 2'd1;
    localparam logic [1:0] SInflight = 2'd2;
    localparam logic [1:0] SDone     = 2'd3;

    logic [bs-1:0][1:0] slot_q, slot_d;
    logic               issue_valid_q, issue_valid_d;
    logic [IW-1:0]      issue_index_q, issue_index_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic               free_valid_q, free_valid_d;
    logic [IW-1:0]      free_index_q, free_index_d;
    logic [CW-1:0]      inflight_q, inflight_d;
    logic               err_q, err_d;

    logic               hs;
    logic               done_ok;
    logic               done_bad;
    logic               alloc_bad;
    logic               kill;
    logic               load;
    logic [CW:0]        infl_sum;
    logic [bs-1:0]      cand;
    logic               found;
    logic [IW-1:0]      pick;
    logic [IW-1:0]      scan_idx;

    assign hs = issue_valid_q & issue_ready;

    // A done is only honoured for an in-flight slot that is not being reallocated this cycle.
    assign done_ok  = done_valid & (slot_q[done_index] == SInflight)
                      & ~(alloc_valid & (alloc_index == done_index));
    assign done_bad = done_valid & ~done_ok;
    assign alloc_bad = alloc_valid & ((slot_q[alloc_index] == SQueued)
                                      | (slot_q[alloc_index] == SInflight));

    // Reallocating the slot currently on offer withdraws the offer.
    assign kill = alloc_valid & issue_valid_q & ~issue_ready & (alloc_index == issue_index_q);

    assign infl_sum = {1'b0, inflight_q} + {{CW{1'b0}}, hs} - {{CW{1'b0}}, done_ok};
    assign load     = (~issue_valid_q | issue_ready) & (infl_sum < (CW + 1)'(MAX_INFLIGHT));

    always_comb begin
        cand = '0;
        for (int j = 0; j < bs; j++) begin
            cand[j] = independent_instr[j] & (slot_q[j] == SIdle)
                      & ~(alloc_valid & (alloc_index == IW'(j)));
        end
    end

    always_comb begin
        found    = 1'b0;
        pick     = rr_q;
        scan_idx = '0;
        for (int k = 0; k < bs; k++) begin
            scan_idx = rr_q + IW'(k);
            if (!found && cand[scan_idx]) begin
                found = 1'b1;
                pick  = scan_idx;
            end
        end
    end

    always_comb begin
        slot_d        = slot_q;
        issue_valid_d = issue_valid_q;
        issue_index_d = issue_index_q;
        rr_d          = rr_q;
        free_valid_d  = done_ok;
        free_index_d  = done_ok ? done_index : free_index_q;
        inflight_d    = infl_sum[CW-1:0];
        err_d         = err_q | done_bad | alloc_bad;

        if (hs) begin
            slot_d[issue_index_q] = SInflight;
            rr_d                  = issue_index_q + IW'(1);
            issue_valid_d         = 1'b0;
        end
        if (done_ok) begin
            slot_d[done_index] = SDone;
        end
        if (load) begin
            if (found) begin
                issue_valid_d = 1'b1;
                issue_index_d = pick;
                slot_d[pick]  = SQueued;
            end else begin
                issue_valid_d = 1'b0;
            end
        end
        if (kill) begin
            issue_valid_d = 1'b0;
        end
        if (alloc_valid) begin
            slot_d[alloc_index] = SIdle;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q        <= '0;
            issue_valid_q <= 1'b0;
            issue_index_q <= '0;
            rr_q          <= '0;
            free_valid_q  <= 1'b0;
            free_index_q  <= '0;
            inflight_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            issue_valid_q <= issue_valid_d;
            issue_index_q <= issue_index_d;
            rr_q          <= rr_d;
            free_valid_q  <= free_valid_d;
            free_index_q  <= free_index_d;
            inflight_q    <= inflight_d;
            err_q         <= err_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_index = issue_index_q;
    assign free_valid  = free_valid_q;
    assign free_index  = free_index_q;
    assign inflight    = inflight_q;
    assign err         = err_q;

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Selects one ready instruction per cycle from the instruction buffer and hands it to the execution unit over a valid/ready handshake. It consumes the per-slot `independent_instr` vector produced by the dependency table (IDT) and tracks each slot through queued, in-flight and done states, so no slot issues twice. It also reports completed slots back to the buffer through `free_valid`/`free_index`, and caps outstanding issues with an in-flight counter.

## Interface
- `bs`, 16: buffer slots; power of two, ≥ 2.
- `MAX_INFLIGHT`, 4: maximum issued-but-not-completed instructions; range 1..`bs`.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `independent_instr`  in  [0:bs-1]  from IDT; bit j=1 means slot j is valid and has no dependencies.
- `alloc_valid`  in  1  new instruction written into slot `alloc_index` this cycle.
- `alloc_index`  in  $clog2(bs)  slot being allocated.
- `issue_valid`  out  1  `issue_index` holds an instruction offered to execution.
- `issue_index`  out  $clog2(bs)  slot being issued.
- `issue_ready`  in  1  execution accepts; transfer when `issue_valid` & `issue_ready`.
- `done_valid`  in  1  execution finished the instruction in slot `done_index`.
- `done_index`  in  $clog2(bs)  completed slot.
- `free_valid`  out  1  one-cycle pulse: slot `free_index` may be released and reallocated.
- `free_index`  out  $clog2(bs)  released slot.
- `inflight`  out  $clog2(bs+1)  current outstanding count.
- `err`  out  1  sticky protocol error; cleared only by reset.

## Operation
- Per-slot 2-bit state:
  - IDLE: waiting, eligible.
  - QUEUED: held in the output register.
  - INFLIGHT: accepted by execution.
  - DONE: completed, awaiting reallocation.
- Candidates = `independent_instr` & (state==IDLE).
- Load condition: (!`issue_valid` | `issue_ready`) & (`inflight` + accepted-this-cycle < `MAX_INFLIGHT`).
- Round-robin pick: the first candidate scanning from `rr_ptr` upward, wrapping from `bs`-1 to 0.
- On load with a candidate present:
  - `issue_index` <= pick; `issue_valid` <= 1; slot becomes QUEUED.
- On load with no candidate:
  - `issue_valid` <= 0; `issue_index` holds its old value.
- When the load condition is false, `issue_valid`/`issue_index` hold their values.
- On handshake:
  - The slot goes QUEUED→INFLIGHT.
  - `rr_ptr` <= `issue_index`+1 (mod `bs`).
  - `inflight`+1.
- `done_valid` with the slot INFLIGHT:
  - Slot becomes DONE; `inflight`-1.
  - Next cycle `free_valid`=1 and `free_index`=`done_index`.
- `done_valid` with the slot in any other state: ignored, `err` set.
- Handshake and done in the same cycle: `inflight` is unchanged.
- `alloc_valid`:
  - The slot becomes IDLE.
  - If the slot was QUEUED or INFLIGHT: `err` set, and if QUEUED, `issue_valid` drops next cycle.
  - Alloc and done to the same slot in the same cycle: alloc wins, done is ignored, `err` is set.
- DONE slots never issue, even if `independent_instr` is still high before the buffer clears valid.

## Timing
- Reset (async assert, sync release):
  - `issue_valid`=0, `issue_index`=0.
  - `free_valid`=0, `free_index`=0.
  - `inflight`=0, `rr_ptr`=0, `err`=0.
  - All slots IDLE.
- A slot marked independent in cycle N appears on `issue_valid` at edge N+1, provided the output register is loadable.
- Back-to-back issue is possible: with `issue_ready` held high, one issue per cycle.
- `issue_valid`/`issue_index` stay stable while `issue_valid` & !`issue_ready`.
- `free_valid` asserts exactly 1 cycle after an accepted `done_valid` and lasts 1 cycle.
- With `inflight`==`MAX_INFLIGHT`, loading is blocked; a done in cycle N allows a load at edge N+1.
- Reset asserted mid-handshake: all outputs clear immediately; the pending offer is discarded.

## Test plan
- Reset, `bs`=16: `independent_instr`=0x0000 → `issue_valid`=0 and `inflight`=0 indefinitely; `err`=0.
- Round-robin: `independent_instr`=0x8081 (slots 0, 8, 15), `issue_ready`=1 → issues slot 0, then 8, then 15 on consecutive cycles, no repeats; `inflight`=3.
- Backpressure: slot 3 offered, `issue_ready`=0 for 5 cycles → `issue_index`=3 stable with `issue_valid`=1; slot 5 becoming independent meanwhile is not offered until slot 3 is accepted.
- In-flight limit, `MAX_INFLIGHT`=4, 6 independent slots:
  - 4 issue, then `issue_valid`=0.
  - `done_valid` for slot 0 → `free_valid`/`free_index`=0 next cycle, and the 5th slot is offered that same cycle.
- Same-cycle events:
  - Handshake plus done → `inflight` unchanged.
  - `alloc_valid` on an INFLIGHT slot → `err`=1 (sticky); the slot becomes IDLE and is reissuable.
- Spurious `done_valid` on an IDLE slot → no `free_valid`, `inflight` unchanged, `err`=1.
